snake_sprite_fetch: RTL and testbench
=====================================

Name: snake_sprite_fetch

Overview:
- Pixel-fetch stage that sits directly upstream of the snake sprite palette lookup.
- Per pixel, it tests whether the VGA beam (DrawX/DrawY) falls inside the snake's sprite box.
- It generates the sprite ROM address, including the animation frame offset, and emits the 4-bit palette index plus a sprite_on flag.
- An internal FSM advances the animation frame on vertical-sync pulses while the snake is moving.

Parameters:
SPR_W, 32, sprite width in pixels (power of 2)
SPR_H, 32, sprite height in pixels (power of 2)
FRAMES, 4, animation frames stored back-to-back in ROM (power of 2)
ANIM_DIV, 8, vsync pulses per animation frame step
ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= FRAMES*SPR_W*SPR_H
TRANSP_IDX, 0, palette index treated as transparent

Ports:
Clk  input  1  pixel clock
Reset  input  1  asynchronous, active-high reset
vsync_pulse  input  1  one-cycle strobe at frame start
moving  input  1  snake in motion; enables animation
snake_x  input  10  sprite top-left X, unsigned
snake_y  input  10  sprite top-left Y, unsigned
DrawX  input  10  current beam X
DrawY  input  10  current beam Y
pix_valid  input  1  beam is in the active display area
rom_addr  output  ADDR_W  sprite ROM address (registered)
rom_q  input  4  sprite ROM data, valid one cycle after rom_addr
palette_index  output  4  index to the palette stage (registered)
sprite_on  output  1  opaque sprite pixel present (registered)
frame  output  log2(FRAMES)  current animation frame

Behaviour:
- Reset (async, active-high) forces these values immediately and holds them while Reset=1:
  - rom_addr=0, palette_index=0, sprite_on=0, frame=0.
  - Shadow position=0, divider=0, FSM=IDLE.
- Shadow position:
  - snake_x/snake_y are latched into shadow registers only on a cycle with vsync_pulse=1.
  - All hit tests use the shadow values, so there is no mid-frame tearing.
- Hit test (combinational, cycle N):
  - hit = pix_valid && DrawX>=sx && DrawX<sx+SPR_W && DrawY>=sy && DrawY<sy+SPR_H.
  - The sums are computed at 11 bits, so sx near 1023 never wraps into a false hit.
- Address:
  - dx=DrawX-sx, dy=DrawY-sy, truncated to log2(SPR_W) and log2(SPR_H) bits.
  - addr = frame*SPR_W*SPR_H + dy*SPR_W + dx, formed by concatenation {frame,dy,dx}.
  - Registered at the end of cycle N; rom_addr updates every cycle regardless of hit.
- Pipeline:
  - hit is delayed alongside the ROM access.
  - rom_q is valid in cycle N+2.
  - At the end of cycle N+2, the block registers:
    - sprite_on = hit_d2 && (rom_q != TRANSP_IDX)
    - palette_index = sprite_on ? rom_q : 0
  - Fixed latency: DrawX/DrawY at cycle N → palette_index/sprite_on visible at cycle N+3.
  - No stalls; one pixel per clock.
- Animation FSM, evaluated only on vsync_pulse cycles:
  - IDLE: frame=0, divider=0. If moving=1, go to WALK.
  - WALK, moving=1: divider increments. When divider reaches ANIM_DIV-1, divider←0 and frame←(frame+1) mod FRAMES.
  - WALK, moving=0: go to IDLE; frame←0 and divider←0 on the same vsync.
  - moving is sampled only at vsync; toggles between vsyncs are ignored.
- frame changes only on the vsync cycle, so a displayed frame never mixes animation frames.
- Reset asserted mid-line: the pipeline is flushed and no stale sprite_on pixel appears after Reset releases.
- The sprite may extend past the visible edge (sx>640-SPR_W); only the on-screen part is drawn and there is no wrap to x=0.

Test Plan:
1. Reset: drive nonzero state, assert Reset between clock edges → all outputs 0 immediately, before the next Clk edge; hold 3 cycles → still 0.
2. Address and latency: vsync with snake_x=100, snake_y=50, frame 0; DrawX=105, DrawY=53, pix_valid=1 at cycle N → rom_addr=3*32+5=101 at N+1; ROM model returns 4'h7 → palette_index=7, sprite_on=1 at N+3.
3. Transparency and bounds (same position as 2):
   - rom_q=0 inside the box → sprite_on=0, index=0.
   - DrawX=132 or DrawY=82 → sprite_on=0.
   - DrawX=131, DrawY=81 → rom_addr=1023.
   - pix_valid=0 inside the box → sprite_on=0.
4. Animation: moving=1, ANIM_DIV=8 → frame=1 after 8 vsync pulses and rom_addr gains a +1024 offset; frame=0 after 32 pulses (wrap); moving=0 at the next vsync → frame=0, FSM IDLE.
5. Shadow latch: change snake_x from 100 to 200 without vsync → hit region stays at 100..131; after vsync → 200..231.
6. Overflow edge: snake_x=1010 → no hit for DrawX 0..9; snake_x=620 → hits at DrawX 620..639 only.

Source files
------------

// File: rtl/snake_sprite_fetch_if.sv
// Signal bundle between the beam/ROM side and the snake sprite fetch stage.
// The slave modport is the fetch block; the master modport drives it.
interface snake_sprite_fetch_if #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned FRAME_W = 2
);
  logic               vsync_pulse;
  logic               moving;
  logic [9:0]         snake_x;
  logic [9:0]         snake_y;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               pix_valid;
  logic [ADDR_W-1:0]  rom_addr;
  logic [3:0]         rom_q;
  logic [3:0]         palette_index;
  logic               sprite_on;
  logic [FRAME_W-1:0] frame;

  modport master (
    output vsync_pulse, moving, snake_x, snake_y, DrawX, DrawY, pix_valid, rom_q,
    input  rom_addr, palette_index, sprite_on, frame
  );

  modport slave (
    input  vsync_pulse, moving, snake_x, snake_y, DrawX, DrawY, pix_valid, rom_q,
    output rom_addr, palette_index, sprite_on, frame
  );
endinterface

// File: rtl/snake_sprite_fetch.sv
// Snake sprite pixel fetch: box hit test, ROM address generation with animation
// frame offset, and a fixed 3-cycle pipeline to palette index / sprite_on.
module snake_sprite_fetch #(
  parameter int unsigned SPR_W      = 32,
  parameter int unsigned SPR_H      = 32,
  parameter int unsigned FRAMES     = 4,
  parameter int unsigned ANIM_DIV   = 8,
  parameter int unsigned ADDR_W     = 12,
  parameter logic [3:0]  TRANSP_IDX = 4'd0
) (
  input logic                  Clk,
  input logic                  Reset,
  snake_sprite_fetch_if.slave  bus
);

  localparam int unsigned XW = $clog2(SPR_W);
  localparam int unsigned YW = $clog2(SPR_H);
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic [0:0] {StIdle, StWalk} state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [DW-1:0]     div_q, div_d;
  logic [9:0]        sx_q, sy_q;
  logic [ADDR_W-1:0] rom_addr_q, addr_d;
  logic              hit_d1_q, hit_d2_q;
  logic              sprite_on_q, on_d;
  logic [3:0]        pal_q;

  logic              hit;
  logic [10:0]       x_ext, y_ext, sx_ext, sy_ext;
  logic [9:0]        dx_full, dy_full;
  logic [XW-1:0]     dx;
  logic [YW-1:0]     dy;

  // 11-bit compares keep a box near x=1023 from wrapping into a false hit.
  assign x_ext  = {1'b0, bus.DrawX};
  assign y_ext  = {1'b0, bus.DrawY};
  assign sx_ext = {1'b0, sx_q};
  assign sy_ext = {1'b0, sy_q};

  assign hit = bus.pix_valid
             && (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(SPR_W))
             && (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(SPR_H));

  assign dx_full = bus.DrawX - sx_q;
  assign dy_full = bus.DrawY - sy_q;
  assign dx      = dx_full[XW-1:0];
  assign dy      = dy_full[YW-1:0];
  assign addr_d  = ADDR_W'({frame_q, dy, dx});

  assign on_d = hit_d2_q && (bus.rom_q != TRANSP_IDX);

  // Shadow position only moves at frame start so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (bus.vsync_pulse) begin
      sx_q <= bus.snake_x;
      sy_q <= bus.snake_y;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      sprite_on_q <= 1'b0;
      pal_q       <= '0;
    end else begin
      rom_addr_q  <= addr_d;
      hit_d1_q    <= hit;
      hit_d2_q    <= hit_d1_q;
      sprite_on_q <= on_d;
      pal_q       <= on_d ? bus.rom_q : 4'd0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.vsync_pulse) begin
      unique case (state_q)
        StIdle:  if (bus.moving)  state_d = StWalk;
        StWalk:  if (!bus.moving) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    frame_d = frame_q;
    div_d   = div_q;
    if (bus.vsync_pulse) begin
      unique case (state_q)
        StWalk: begin
          if (!bus.moving) begin
            frame_d = '0;
            div_d   = '0;
          end else if (div_q == DW'(ANIM_DIV - 1)) begin
            div_d   = '0;
            frame_d = frame_q + 1'b1;
          end else begin
            div_d   = div_q + 1'b1;
          end
        end
        default: begin
          frame_d = '0;
          div_d   = '0;
        end
      endcase
    end
  end

  assign bus.rom_addr      = rom_addr_q;
  assign bus.palette_index = pal_q;
  assign bus.sprite_on     = sprite_on_q;
  assign bus.frame         = frame_q;

endmodule

// File: tb/tb_snake_sprite_fetch.sv
// Scoreboard bench for snake_sprite_fetch: the driver queues hand-derived
// expectations, a negedge monitor pops and compares them at their due cycle.
`timescale 1ns/1ps
module tb_snake_sprite_fetch;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [3:0] rom [4096];

  typedef struct {
    int    due;
    int    val_a;
    int    val_b;
    string nm;
  } exp_t;

  exp_t out_q[$];
  exp_t addr_q[$];

  snake_sprite_fetch_if #(.ADDR_W(12), .FRAME_W(2)) bus ();

  snake_sprite_fetch dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous sprite ROM: data follows rom_addr by one clock.
  always @(posedge Clk) bus.rom_q <= rom[bus.rom_addr];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      exp_t a;
      a = addr_q.pop_front();
      if (a.due == cyc) chk({a.nm, "_addr"}, int'(bus.rom_addr), a.val_a);
      else begin
        total++; bad++;
        $display("FAIL %s_addr: expectation skipped at cycle %0d", a.nm, cyc);
      end
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      exp_t o;
      o = out_q.pop_front();
      if (o.due == cyc) begin
        chk({o.nm, "_on"}, int'(bus.sprite_on), o.val_a);
        chk({o.nm, "_idx"}, int'(bus.palette_index), o.val_b);
      end else begin
        total++; bad++;
        $display("FAIL %s_out: expectation skipped at cycle %0d", o.nm, cyc);
      end
    end
  end

  // One pixel for one clock; hit/addr are hand-derived per call.
  task automatic pix(input string nm, input int x, input int y, input bit pv,
                     input bit hit, input int addr, input bit check_addr);
    exp_t e;
    int   on;
    @(posedge Clk); #1;
    bus.vsync_pulse = 1'b0;
    bus.DrawX       = 10'(x);
    bus.DrawY       = 10'(y);
    bus.pix_valid   = pv;
    on = (hit && rom[addr] != 4'd0) ? 1 : 0;
    e.nm = nm; e.due = cyc + 3; e.val_a = on; e.val_b = on ? int'(rom[addr]) : 0;
    out_q.push_back(e);
    if (check_addr) begin
      e.due = cyc + 1; e.val_a = addr; e.val_b = 0;
      addr_q.push_back(e);
    end
  endtask

  task automatic idle(input string nm);
    exp_t e;
    @(posedge Clk); #1;
    bus.vsync_pulse = 1'b0;
    bus.pix_valid   = 1'b0;
    e.nm = nm; e.due = cyc + 3; e.val_a = 0; e.val_b = 0;
    out_q.push_back(e);
  endtask

  task automatic vsync(input bit mv);
    @(posedge Clk); #1;
    bus.vsync_pulse = 1'b1;
    bus.pix_valid   = 1'b0;
    bus.moving      = mv;
    @(posedge Clk); #1;
    bus.vsync_pulse = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"},  int'(bus.rom_addr), 0);
    chk({nm, "_idx"},   int'(bus.palette_index), 0);
    chk({nm, "_on"},    int'(bus.sprite_on), 0);
    chk({nm, "_frame"}, int'(bus.frame), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 4'((i % 15) + 1);
    rom[101]  = 4'h7;
    rom[102]  = 4'h0;
    rom[1023] = 4'hc;

    bus.vsync_pulse = 1'b0;
    bus.moving      = 1'b0;
    bus.snake_x     = '0;
    bus.snake_y     = '0;
    bus.DrawX       = '0;
    bus.DrawY       = '0;
    bus.pix_valid   = 1'b0;

    repeat (3) @(posedge Clk);
    #1;
    chk_zero("reset_init");
    Reset = 1'b0;

    // Address, latency, transparency and box bounds at (100,50).
    bus.snake_x = 10'd100;
    bus.snake_y = 10'd50;
    vsync(1'b0);
    pix("base",    105, 53, 1'b1, 1'b1, 101,  1'b1);
    pix("transp",  106, 53, 1'b1, 1'b1, 102,  1'b1);
    pix("x_edge",  132, 53, 1'b1, 1'b0, 96,   1'b1);
    pix("y_edge",  105, 82, 1'b1, 1'b0, 5,    1'b1);
    pix("corner",  131, 81, 1'b1, 1'b1, 1023, 1'b1);
    pix("x_below",  99, 53, 1'b1, 1'b0, 0,    1'b0);
    pix("pv_off",  105, 53, 1'b0, 1'b0, 101,  1'b1);

    // Shadow latch: position only moves on vsync.
    bus.snake_x = 10'd200;
    pix("shadow_old",  110, 53, 1'b1, 1'b1, 106, 1'b1);
    pix("shadow_pre",  205, 53, 1'b1, 1'b0, 0,   1'b0);
    vsync(1'b0);
    pix("shadow_new",  205, 53, 1'b1, 1'b1, 101, 1'b1);
    pix("shadow_gone", 110, 53, 1'b1, 1'b0, 0,   1'b0);

    // Box near x=1023 must not wrap onto the left edge.
    bus.snake_x = 10'd1010;
    vsync(1'b0);
    for (int x = 0; x < 10; x++) pix("wrap_left", x, 53, 1'b1, 1'b0, 0, 1'b0);
    pix("far_right", 1015, 53, 1'b1, 1'b1, 101, 1'b1);

    // Partially off-screen box: only 620..639 are drawn.
    bus.snake_x = 10'd620;
    vsync(1'b0);
    for (int x = 618; x < 642; x++) begin
      if (x >= 620 && x < 640) pix("edge_in", x, 53, 1'b1, 1'b1, 96 + x - 620, 1'b1);
      else                     pix("edge_out", x, 53, (x < 640), 1'b0, 0, 1'b0);
    end

    // Animation: entering vsync, then one frame step per 8 walking vsyncs.
    bus.snake_x = 10'd100;
    vsync(1'b1);
    chk("anim_enter", int'(bus.frame), 0);
    repeat (7) vsync(1'b1);
    chk("anim_7", int'(bus.frame), 0);
    vsync(1'b1);
    chk("anim_8", int'(bus.frame), 1);
    pix("anim_addr", 105, 53, 1'b1, 1'b1, 1125, 1'b1);
    repeat (23) vsync(1'b1);
    chk("anim_31", int'(bus.frame), 3);
    vsync(1'b1);
    chk("anim_wrap", int'(bus.frame), 0);
    repeat (8) vsync(1'b1);
    chk("anim_40", int'(bus.frame), 1);
    vsync(1'b0);
    chk("anim_stop", int'(bus.frame), 0);
    vsync(1'b1);
    repeat (7) vsync(1'b1);
    chk("anim_div_clr", int'(bus.frame), 0);
    vsync(1'b1);
    chk("anim_restart", int'(bus.frame), 1);

    // Reset mid-line with frame=1 and an opaque pixel on the output.
    pix("pre_rst", 105, 53, 1'b1, 1'b1, 1125, 1'b1);
    repeat (3) idle("pre_rst_idle");
    @(negedge Clk); #1;
    out_q.delete();
    addr_q.delete();
    Reset = 1'b1;
    #1;
    chk_zero("reset_async");
    repeat (3) begin
      @(negedge Clk);
      chk_zero("reset_hold");
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (4) idle("post_rst_idle");
    pix("post_rst", 5, 3, 1'b1, 1'b1, 101, 1'b1);
    repeat (2) idle("tail");

    repeat (6) @(negedge Clk);
    #1;
    if (out_q.size() != 0 || addr_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d/%0d expectations left", out_q.size(), addr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
